pmf_fu_pipe: RTL and testbench



---
 rtl/pmf_fu_pipe_if.sv | 28 ++
 rtl/pmf_fu_pipe.sv | 92 +++++++++
 tb/tb_pmf_fu_pipe.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmf_fu_pipe_if.sv
// rtl/pmf_fu_pipe_if.sv - issue and CDB handshake bundle for the pmf functional unit
interface pmf_fu_pipe_if #(
    parameter int DATA_W  = 32,
    parameter int LABEL_W = 4
) ();
    logic               WEN;
    logic               available;
    logic [2:0]         op;
    logic [DATA_W-1:0]  dataIn1;
    logic [DATA_W-1:0]  dataIn2;
    logic [LABEL_W-1:0] labelIn;
    logic               require;
    logic               requireAC;
    logic [DATA_W-1:0]  result;
    logic [LABEL_W-1:0] labelOut;

    // master: reservation station plus CDB arbiter side
    modport master (
        output WEN, op, dataIn1, dataIn2, labelIn, requireAC,
        input  available, require, result, labelOut
    );

    // slave: the functional unit
    modport slave (
        input  WEN, op, dataIn1, dataIn2, labelIn, requireAC,
        output available, require, result, labelOut
    );
endinterface

// File: rtl/pmf_fu_pipe.sv
// rtl/pmf_fu_pipe.sv - DEPTH-stage Tomasulo functional unit with CDB back-pressure; PMF_FU_FLUSH_EN adds a flush input
module pmf_fu_pipe #(
    parameter int DATA_W  = 32,
    parameter int LABEL_W = 4,
    parameter int DEPTH   = 2
) (
    input  logic clk,
    input  logic RST,
`ifdef PMF_FU_FLUSH_EN
    input  logic flush,
`endif
    pmf_fu_pipe_if.slave fu
);
    localparam int SH_W = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [DEPTH-1:0]   v;
    logic [DATA_W-1:0]  res [DEPTH];
    logic [LABEL_W-1:0] lab [DEPTH];
    logic [DEPTH-1:0]   adv;
    logic [DATA_W-1:0]  alu;
    logic               flush_w;
    logic               avail;
    logic               accept;

`ifdef PMF_FU_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    always_comb begin
        alu = '0;
        case (fu.op)
            3'd0: alu = fu.dataIn1 + fu.dataIn2;
            3'd1: alu = fu.dataIn1 + ~fu.dataIn2 + ONE;
            3'd2: alu = fu.dataIn1 & fu.dataIn2;
            3'd3: alu = fu.dataIn1 | fu.dataIn2;
            3'd4: alu = fu.dataIn1 ^ fu.dataIn2;
            3'd5: alu = {{(DATA_W-1){1'b0}}, ($signed(fu.dataIn1) < $signed(fu.dataIn2))};
            3'd6: alu = fu.dataIn1 << fu.dataIn2[SH_W-1:0];
            3'd7: alu = fu.dataIn1 >> fu.dataIn2[SH_W-1:0];
            default: alu = '0;
        endcase
    end

    // Advance resolves from the head backwards so a grant ripples through a full pipe in one cycle.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = v[DEPTH-1] & fu.requireAC;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = v[i] & (~v[i+1] | adv[i+1]);
        end
    end

    assign avail  = (~v[0] | adv[0]) & ~flush_w;
    assign accept = fu.WEN & avail;

    always_ff @(posedge clk) begin
        if (RST) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                res[i] <= '0;
                lab[i] <= '0;
            end
        end else if (flush_w) begin
            v <= '0;
        end else begin
            if (accept) begin
                v[0]   <= 1'b1;
                res[0] <= alu;
                lab[0] <= fu.labelIn;
            end else if (adv[0]) begin
                v[0] <= 1'b0;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (adv[i-1]) begin
                    v[i]   <= 1'b1;
                    res[i] <= res[i-1];
                    lab[i] <= lab[i-1];
                end else if (adv[i]) begin
                    v[i] <= 1'b0;
                end
            end
        end
    end

    assign fu.available = avail;
    assign fu.require   = v[DEPTH-1];
    assign fu.result    = res[DEPTH-1];
    assign fu.labelOut  = lab[DEPTH-1];
endmodule

// File: tb/tb_pmf_fu_pipe.sv
// tb/tb_pmf_fu_pipe.sv - scoreboard bench for pmf_fu_pipe with directed vectors
module tb_pmf_fu_pipe;
    localparam int DATA_W  = 32;
    localparam int LABEL_W = 4;
    localparam int DEPTH   = 2;

    logic clk = 1'b0;
    logic RST;
`ifdef PMF_FU_FLUSH_EN
    logic flush;
`endif

    pmf_fu_pipe_if #(.DATA_W(DATA_W), .LABEL_W(LABEL_W)) fu ();

    pmf_fu_pipe #(.DATA_W(DATA_W), .LABEL_W(LABEL_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .RST   (RST),
`ifdef PMF_FU_FLUSH_EN
        .flush (flush),
`endif
        .fu    (fu)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  label;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every CDB grant consumes the oldest expected entry.
    always @(negedge clk) begin
        if (RST === 1'b0 && fu.require === 1'b1 && fu.requireAC === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_grant: got label 0x%0h, expected no entry", fu.labelOut);
            end else begin
                mon_e = sb.pop_front();
                chk("cdb_result", fu.result, mon_e.data);
                chk("cdb_label", {28'b0, fu.labelOut}, {28'b0, mon_e.label});
            end
        end
    end

    // Called and returns #1 after a rising edge; leaves WEN asserted for back-to-back issues.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] lbl, input logic [31:0] exp_data);
        int n;
        fu.WEN     = 1'b1;
        fu.op      = op;
        fu.dataIn1 = a;
        fu.dataIn2 = b;
        fu.labelIn = lbl;
        n = 0;
        @(negedge clk);
        while (fu.available !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        if (n >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL issue_timeout: label %0d got available=0, expected acceptance", lbl);
        end else begin
            sb.push_back('{data: exp_data, label: lbl});
        end
        #1;
    endtask

    task automatic measure_latency(output int lat);
        lat = 1;
        while (lat < 30) begin
            @(negedge clk);
            if (fu.require === 1'b1) break;
            @(posedge clk);
            lat++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic count_require(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (fu.require === 1'b1) c++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int cnt;
        RST          = 1'b1;
        fu.WEN       = 1'b0;
        fu.op        = 3'd0;
        fu.dataIn1   = '0;
        fu.dataIn2   = '0;
        fu.labelIn   = '0;
        fu.requireAC = 1'b0;
`ifdef PMF_FU_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        RST = 1'b0;
        @(negedge clk);
        chk("reset_require", {31'b0, fu.require}, 32'd0);
        chk("reset_result", fu.result, 32'd0);
        chk("reset_label", {28'b0, fu.labelOut}, 32'd0);
        chk("reset_available", {31'b0, fu.available}, 32'd1);
        step();

        // Single ADD: 5 + 7, label 3
        fu.requireAC = 1'b1;
        issue(3'd0, 32'd5, 32'd7, 4'd3, 32'd12);
        fu.WEN = 1'b0;
        measure_latency(lat);
        chk("add_latency", lat, DEPTH);
        @(negedge clk);
        chk("add_require_one_cycle", {31'b0, fu.require}, 32'd0);
        step();

        // Operation table, back-to-back
        issue(3'd1, 32'd3,          32'd5,          4'd1, 32'hFFFF_FFFE);
        issue(3'd5, 32'hFFFF_FFFF,  32'd1,          4'd2, 32'd1);
        issue(3'd5, 32'd1,          32'hFFFF_FFFF,  4'd3, 32'd0);
        issue(3'd7, 32'h8000_0000,  32'h21,         4'd4, 32'h4000_0000);
        issue(3'd6, 32'd1,          32'hFFFF_FFFF,  4'd5, 32'h8000_0000);
        issue(3'd2, 32'h0000_F0F0,  32'h0000_FF00,  4'd6, 32'h0000_F000);
        issue(3'd3, 32'h0000_F0F0,  32'h0000_FF00,  4'd7, 32'h0000_FFF0);
        issue(3'd4, 32'h0000_F0F0,  32'h0000_FF00,  4'd8, 32'h0000_0FF0);
        issue(3'd0, 32'hFFFF_FFFF,  32'd2,          4'd9, 32'd1);
        fu.WEN = 1'b0;
        repeat (DEPTH + 2) step();

        // Back-pressure: pipe fills, third issue waits for the grant
        fu.requireAC = 1'b0;
        issue(3'd0, 32'd1, 32'd0, 4'd1, 32'd1);
        issue(3'd0, 32'd2, 32'd0, 4'd2, 32'd2);
        fu.WEN     = 1'b1;
        fu.op      = 3'd0;
        fu.dataIn1 = 32'd3;
        fu.dataIn2 = 32'd0;
        fu.labelIn = 4'd3;
        @(negedge clk);
        chk("bp_full_available", {31'b0, fu.available}, 32'd0);
        chk("bp_full_require", {31'b0, fu.require}, 32'd1);
        chk("bp_full_label", {28'b0, fu.labelOut}, 32'd1);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold_label", {28'b0, fu.labelOut}, 32'd1);
            chk("bp_hold_available", {31'b0, fu.available}, 32'd0);
        end
        step();
        fu.requireAC = 1'b1;
        @(negedge clk);
        chk("bp_grant_available", {31'b0, fu.available}, 32'd1);
        @(posedge clk);
        sb.push_back('{data: 32'd3, label: 4'd3});
        #1;
        fu.WEN = 1'b0;
        @(negedge clk);
        chk("bp_drain_label2", {28'b0, fu.labelOut}, 32'd2);
        @(negedge clk);
        chk("bp_drain_label3", {28'b0, fu.labelOut}, 32'd3);
        @(negedge clk);
        chk("bp_drain_empty", {31'b0, fu.require}, 32'd0);
        step();

        // Sustained stream of 8
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    issue(3'd0, i, 32'd100, i[3:0], i + 100);
                end
                fu.WEN = 1'b0;
            end
            begin
                int n;
                n = 0;
                cnt = 0;
                @(negedge clk);
                while (fu.require !== 1'b1 && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                while (fu.require === 1'b1 && cnt < 20) begin
                    cnt++;
                    @(negedge clk);
                end
            end
        join
        chk("stream_require_cycles", cnt, 32'd8);
        repeat (2) step();

        // Reset with two entries in flight and a pending issue and grant
        fu.requireAC = 1'b0;
        issue(3'd0, 32'h55, 32'd0, 4'd9, 32'h55);
        issue(3'd0, 32'h66, 32'd0, 4'd10, 32'h66);
        fu.labelIn   = 4'd11;
        fu.requireAC = 1'b1;
        RST          = 1'b1;
        step();
        RST    = 1'b0;
        fu.WEN = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midreset_require", {31'b0, fu.require}, 32'd0);
        chk("midreset_result", fu.result, 32'd0);
        chk("midreset_label", {28'b0, fu.labelOut}, 32'd0);
        chk("midreset_available", {31'b0, fu.available}, 32'd1);
        count_require(4, cnt);
        chk("midreset_no_stale", cnt, 32'd0);

`ifdef PMF_FU_FLUSH_EN
        // Flush with two entries valid and an issue pending
        fu.requireAC = 1'b0;
        issue(3'd0, 32'h11, 32'd0, 4'd4, 32'h11);
        issue(3'd0, 32'h22, 32'd0, 4'd5, 32'h22);
        fu.labelIn = 4'd12;
        flush      = 1'b1;
        @(negedge clk);
        chk("flush_available", {31'b0, fu.available}, 32'd0);
        step();
        flush  = 1'b0;
        fu.WEN = 1'b0;
        sb.delete();
        fu.requireAC = 1'b1;
        count_require(4, cnt);
        chk("flush_no_require", cnt, 32'd0);
        issue(3'd4, 32'hF0, 32'h0F, 4'd13, 32'hFF);
        fu.WEN = 1'b0;
        measure_latency(lat);
        chk("flush_next_latency", lat, DEPTH);
        step();
`endif

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
